// File: rtl/dict_update_ctrl_if.sv
// Bus between the match stage and the dictionary write scheduler.
// The match stage drives the beat as master and the scheduler answers as slave.
interface dict_update_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 8
);
  localparam int CW = $clog2(SIZE) + 1;

  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_word0;
  logic [DATA_WIDTH-1:0] i_word1;
  logic                  i_push0;
  logic                  i_push1;
  logic                  i_last;
  logic                  i_clear;
  logic                  o_wr;
  logic                  o_wr2;
  logic [DATA_WIDTH-1:0] o_w_data;
  logic [DATA_WIDTH-1:0] o_w_data2;
  logic                  o_dict_rst_n;
  logic [CW-1:0]         o_cnt1;
  logic [CW-1:0]         o_cnt2;
  logic                  o_full;
  logic                  o_done;

  modport master (
    output i_valid, i_word0, i_word1, i_push0, i_push1, i_last, i_clear,
    input  o_ready, o_wr, o_wr2, o_w_data, o_w_data2, o_dict_rst_n,
           o_cnt1, o_cnt2, o_full, o_done
  );

  modport slave (
    input  i_valid, i_word0, i_word1, i_push0, i_push1, i_last, i_clear,
    output o_ready, o_wr, o_wr2, o_w_data, o_w_data2, o_dict_rst_n,
           o_cnt1, o_cnt2, o_full, o_done
  );
endinterface

// File: rtl/dict_update_ctrl.sv
// Write scheduler for the two-bank dual-write dictionary FIFO.
// Steers inserted candidate words alternately onto the two bank write ports,
// tracks per-bank occupancy, and sequences end-of-block drain and clear.
module dict_update_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 8,
  parameter bit AUTO_CLEAR = 1'b1
) (
  input logic             i_clk,
  input logic             i_reset,
  dict_update_ctrl_if.slave bus
);
  localparam int CW = $clog2(SIZE) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SIZE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, CLEAR} state_t;

  state_t                state_q, state_d;
  logic                  sel_q, sel_d;
  logic                  wr1_q, wr1_d;
  logic                  wr2_q, wr2_d;
  logic [DATA_WIDTH-1:0] wData1_q, wData1_d;
  logic [DATA_WIDTH-1:0] wData2_q, wData2_d;
  logic [CW-1:0]         cnt1_q, cnt1_d;
  logic [CW-1:0]         cnt2_q, cnt2_d;
  logic                  dictRstN_q, dictRstN_d;
  logic                  done_q, done_d;
  logic                  ready;
  logic                  accept;
  logic [DATA_WIDTH-1:0] firstWord;
  logic                  bothPush;
  logic                  anyPush;

  // Next-state, bank steering, occupancy and handshake decisions for this cycle.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    wr1_d      = 1'b0;
    wr2_d      = 1'b0;
    wData1_d   = wData1_q;
    wData2_d   = wData2_q;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    dictRstN_d = 1'b1;
    done_d     = (state_q == DRAIN);

    ready     = ((state_q == IDLE) || (state_q == RUN)) && !bus.i_clear;
    accept    = ready && bus.i_valid;
    bothPush  = bus.i_push0 && bus.i_push1;
    anyPush   = bus.i_push0 || bus.i_push1;
    firstWord = bus.i_push0 ? bus.i_word0 : bus.i_word1;

    if (accept && anyPush) begin
      if (!sel_q) begin
        wr1_d    = 1'b1;
        wData1_d = firstWord;
        if (bothPush) begin
          wr2_d    = 1'b1;
          wData2_d = bus.i_word1;
        end
      end else begin
        wr2_d    = 1'b1;
        wData2_d = firstWord;
        if (bothPush) begin
          wr1_d    = 1'b1;
          wData1_d = bus.i_word1;
        end
      end
      if (!bothPush) begin
        sel_d = !sel_q;
      end
    end

    if (wr1_d && (cnt1_q != CNT_MAX)) begin
      cnt1_d = cnt1_q + CW'(1);
    end
    if (wr2_d && (cnt2_q != CNT_MAX)) begin
      cnt2_d = cnt2_q + CW'(1);
    end

    case (state_q)
      IDLE, RUN: begin
        if (bus.i_clear) begin
          state_d = CLEAR;
        end else if (accept) begin
          state_d = bus.i_last ? DRAIN : RUN;
        end
      end
      DRAIN:   state_d = AUTO_CLEAR ? CLEAR : IDLE;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == CLEAR) begin
      dictRstN_d = 1'b0;
      cnt1_d     = '0;
      cnt2_d     = '0;
      sel_d      = 1'b0;
    end
  end

  // Registers everything; reset discards any partial block immediately.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      wr1_q      <= 1'b0;
      wr2_q      <= 1'b0;
      wData1_q   <= '0;
      wData2_q   <= '0;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      dictRstN_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      wr1_q      <= wr1_d;
      wr2_q      <= wr2_d;
      wData1_q   <= wData1_d;
      wData2_q   <= wData2_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      dictRstN_q <= dictRstN_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_wr         = wr1_q;
  assign bus.o_wr2        = wr2_q;
  assign bus.o_w_data     = wData1_q;
  assign bus.o_w_data2    = wData2_q;
  assign bus.o_dict_rst_n = dictRstN_q;
  assign bus.o_cnt1       = cnt1_q;
  assign bus.o_cnt2       = cnt2_q;
  assign bus.o_full       = (cnt1_q == CNT_MAX) && (cnt2_q == CNT_MAX);
  assign bus.o_done       = done_q;
endmodule

// File: tb/tb_dict_update_ctrl.sv
// Directed bench for the dictionary write scheduler (DATA_WIDTH=32, SIZE=8, AUTO_CLEAR=1).
module tb_dict_update_ctrl;
  logic clk;
  logic rstN;
  int   testCount;
  int   failCount;

  dict_update_ctrl_if #(.DATA_WIDTH(32), .SIZE(8)) bus ();

  dict_update_ctrl #(.DATA_WIDTH(32), .SIZE(8), .AUTO_CLEAR(1'b1)) dut (
    .i_clk   (clk),
    .i_reset (rstN),
    .bus     (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    bus.i_valid = 1'b0;
    bus.i_word0 = '0;
    bus.i_word1 = '0;
    bus.i_push0 = 1'b0;
    bus.i_push1 = 1'b0;
    bus.i_last  = 1'b0;
    bus.i_clear = 1'b0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic driveBeat(input logic p0, input logic p1, input logic last, input logic clr,
                           input logic [31:0] w0, input logic [31:0] w1);
    bus.i_valid = 1'b1;
    bus.i_push0 = p0;
    bus.i_push1 = p1;
    bus.i_last  = last;
    bus.i_clear = clr;
    bus.i_word0 = w0;
    bus.i_word1 = w1;
  endtask

  task automatic applyStimulus(input logic p0, input logic p1, input logic last,
                               input logic [31:0] w0, input logic [31:0] w1);
    driveBeat(p0, p1, last, 1'b0, w0, w1);
    stepCycle();
    idleInputs();
  endtask

  initial begin
    logic [31:0] wordsA [4];
    logic [31:0] expCnt;
    testCount = 0;
    failCount = 0;
    wordsA[0] = 32'h0000_00A0;
    wordsA[1] = 32'h0000_00A1;
    wordsA[2] = 32'h0000_00A2;
    wordsA[3] = 32'h0000_00A3;
    idleInputs();
    rstN = 1'b0;

    // Reset state.
    stepCycle();
    stepCycle();
    checkOutput("rst_wr",     32'(bus.o_wr), 0);
    checkOutput("rst_wr2",    32'(bus.o_wr2), 0);
    checkOutput("rst_data1",  bus.o_w_data, 0);
    checkOutput("rst_cnt1",   32'(bus.o_cnt1), 0);
    checkOutput("rst_cnt2",   32'(bus.o_cnt2), 0);
    checkOutput("rst_done",   32'(bus.o_done), 0);
    checkOutput("rst_dictn",  32'(bus.o_dict_rst_n), 0);
    checkOutput("rst_ready",  32'(bus.o_ready), 1);
    rstN = 1'b1;
    #1;
    checkOutput("rel_dictn_pre", 32'(bus.o_dict_rst_n), 0);
    stepCycle();
    checkOutput("rel_dictn_post", 32'(bus.o_dict_rst_n), 1);

    // Two-push beat: A to bank1, B to bank2.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hAAAA_0001, 32'hBBBB_0002);
    checkOutput("dual_wr",    32'(bus.o_wr), 1);
    checkOutput("dual_wr2",   32'(bus.o_wr2), 1);
    checkOutput("dual_data1", bus.o_w_data, 32'hAAAA_0001);
    checkOutput("dual_data2", bus.o_w_data2, 32'hBBBB_0002);
    checkOutput("dual_cnt1",  32'(bus.o_cnt1), 1);
    checkOutput("dual_cnt2",  32'(bus.o_cnt2), 1);

    // Single pushes alternate banks 1,2,1,2; the idle bank holds its data.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, wordsA[k], 32'hDEAD_BEEF);
      checkOutput($sformatf("alt%0d_wr", k),  32'(bus.o_wr),  (k % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("alt%0d_wr2", k), 32'(bus.o_wr2), (k % 2 == 1) ? 1 : 0);
      checkOutput($sformatf("alt%0d_data1", k), bus.o_w_data,
                  (k == 0) ? wordsA[0] : ((k < 2) ? wordsA[0] : wordsA[2]));
      checkOutput($sformatf("alt%0d_data2", k), bus.o_w_data2,
                  (k == 0) ? 32'hBBBB_0002 : ((k < 3) ? wordsA[1] : wordsA[3]));
    end
    checkOutput("alt_cnt1", 32'(bus.o_cnt1), 3);
    checkOutput("alt_cnt2", 32'(bus.o_cnt2), 3);

    // Twelve two-push beats from 3/3: saturate at 8, full from the fifth write on.
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h1000_0000 + k, 32'h2000_0000 + k);
      expCnt = (3 + k > 8) ? 32'd8 : 32'(3 + k);
      checkOutput($sformatf("sat%0d_wr", k),    32'(bus.o_wr & bus.o_wr2), 1);
      checkOutput($sformatf("sat%0d_data1", k), bus.o_w_data,  32'h1000_0000 + k);
      checkOutput($sformatf("sat%0d_data2", k), bus.o_w_data2, 32'h2000_0000 + k);
      checkOutput($sformatf("sat%0d_cnt1", k),  32'(bus.o_cnt1), expCnt);
      checkOutput($sformatf("sat%0d_cnt2", k),  32'(bus.o_cnt2), expCnt);
      checkOutput($sformatf("sat%0d_full", k),  32'(bus.o_full), (k >= 5) ? 1 : 0);
    end

    // Only push1: word1 goes to bank1 because sel is still 0.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h3333_0000, 32'h4444_0001);
    checkOutput("p1_wr",    32'(bus.o_wr), 1);
    checkOutput("p1_wr2",   32'(bus.o_wr2), 0);
    checkOutput("p1_data1", bus.o_w_data, 32'h4444_0001);

    // Last beat: sel is now 1, so word0 lands in bank2; then DRAIN, CLEAR, IDLE.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h5555_0002, 32'h0);
    checkOutput("drain_wr",    32'(bus.o_wr), 0);
    checkOutput("drain_wr2",   32'(bus.o_wr2), 1);
    checkOutput("drain_data2", bus.o_w_data2, 32'h5555_0002);
    checkOutput("drain_ready", 32'(bus.o_ready), 0);
    checkOutput("drain_done",  32'(bus.o_done), 0);
    checkOutput("drain_dictn", 32'(bus.o_dict_rst_n), 1);
    stepCycle();
    checkOutput("clr_ready", 32'(bus.o_ready), 0);
    checkOutput("clr_done",  32'(bus.o_done), 1);
    checkOutput("clr_dictn", 32'(bus.o_dict_rst_n), 0);
    checkOutput("clr_cnt1",  32'(bus.o_cnt1), 0);
    checkOutput("clr_cnt2",  32'(bus.o_cnt2), 0);
    checkOutput("clr_full",  32'(bus.o_full), 0);
    checkOutput("clr_wr",    32'(bus.o_wr | bus.o_wr2), 0);
    stepCycle();
    checkOutput("idle_ready", 32'(bus.o_ready), 1);
    checkOutput("idle_done",  32'(bus.o_done), 0);
    checkOutput("idle_dictn", 32'(bus.o_dict_rst_n), 1);

    // i_clear with a valid beat in RUN: beat refused, clear follows, no done.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h6666_0000, 32'h0);
    checkOutput("c0_wr",   32'(bus.o_wr), 1);
    checkOutput("c0_cnt1", 32'(bus.o_cnt1), 1);
    driveBeat(1'b1, 1'b1, 1'b0, 1'b1, 32'h7777_0000, 32'h7777_0001);
    #1;
    checkOutput("reqclr_ready", 32'(bus.o_ready), 0);
    stepCycle();
    idleInputs();
    checkOutput("reqclr_wr",    32'(bus.o_wr | bus.o_wr2), 0);
    checkOutput("reqclr_dictn", 32'(bus.o_dict_rst_n), 0);
    checkOutput("reqclr_cnt1",  32'(bus.o_cnt1), 0);
    checkOutput("reqclr_done",  32'(bus.o_done), 0);
    checkOutput("reqclr_data1", bus.o_w_data, 32'h6666_0000);
    stepCycle();
    checkOutput("reqclr_after_done",  32'(bus.o_done), 0);
    checkOutput("reqclr_after_ready", 32'(bus.o_ready), 1);

    // Valid beat with no pushes: no write.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h8888_0000, 32'h8888_0001);
    checkOutput("nopush_wr", 32'(bus.o_wr | bus.o_wr2), 0);
    checkOutput("nopush_cnt1", 32'(bus.o_cnt1), 0);

    // Three writes then async reset mid-RUN.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h9000_0000, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h9000_0001, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h9000_0002, 32'h0);
    checkOutput("pre_rst_data1", bus.o_w_data, 32'h9000_0002);
    checkOutput("pre_rst_cnt1",  32'(bus.o_cnt1), 2);
    checkOutput("pre_rst_cnt2",  32'(bus.o_cnt2), 1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midrst_wr",    32'(bus.o_wr), 0);
    checkOutput("midrst_data1", bus.o_w_data, 0);
    checkOutput("midrst_data2", bus.o_w_data2, 0);
    checkOutput("midrst_cnt1",  32'(bus.o_cnt1), 0);
    checkOutput("midrst_cnt2",  32'(bus.o_cnt2), 0);
    checkOutput("midrst_dictn", 32'(bus.o_dict_rst_n), 0);
    rstN = 1'b1;
    stepCycle();
    checkOutput("post_rst_ready", 32'(bus.o_ready), 1);
    checkOutput("post_rst_dictn", 32'(bus.o_dict_rst_n), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'hE000_0001);
    checkOutput("post_rst_wr",    32'(bus.o_wr), 1);
    checkOutput("post_rst_data1", bus.o_w_data, 32'hE000_0001);
    checkOutput("post_rst_ready2", 32'(bus.o_ready), 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
